// File: rtl/alu_sequencer.sv
//==============================================================================
// Module   : alu_sequencer
// Brief    : Multi-cycle ALU: single-cycle ops, iterative shifts, shift-add MUL.
// Revision : 1.0
//==============================================================================
`default_nettype none

module alu_sequencer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dr0,
    input  logic [DATA_WIDTH-1:0] dr1,
    input  logic [DATA_WIDTH-1:0] cr,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic [3:0]            flags,
    output logic                  err
);

    localparam int c_CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_AND = 4'd2;
    localparam logic [3:0] c_OP_OR  = 4'd3;
    localparam logic [3:0] c_OP_XOR = 4'd4;
    localparam logic [3:0] c_OP_SHL = 4'd5;
    localparam logic [3:0] c_OP_SHR = 4'd6;
    localparam logic [3:0] c_OP_MUL = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_SHIFT = 3'd2,
        S_MUL   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [3:0]            r_op;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_result;
    logic [DATA_WIDTH-1:0] r_result_hi;
    logic [3:0]            r_flags;
    logic                  r_err;

    logic [3:0]            w_op_in;
    logic                  w_is_shift_in;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH-1:0] w_sh_val;
    logic                  w_sh_out;
    logic [DATA_WIDTH:0]   w_mul_sum;
    logic [DATA_WIDTH-1:0] w_mul_hi;
    logic [DATA_WIDTH-1:0] w_mul_lo;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_res;
    logic [DATA_WIDTH-1:0] w_res_hi;
    logic                  w_c;
    logic                  w_v;
    logic                  w_err;
    logic                  w_unused_cr;

    assign w_op_in       = cr[3:0];
    assign w_unused_cr   = ^cr[DATA_WIDTH-1:4];
    assign w_is_shift_in = (w_op_in == c_OP_SHL) || (w_op_in == c_OP_SHR);

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    assign w_sh_val = (r_op == c_OP_SHL) ? {r_a[DATA_WIDTH-2:0], 1'b0}
                                         : {1'b0, r_a[DATA_WIDTH-1:1]};
    assign w_sh_out = (r_op == c_OP_SHL) ? r_a[DATA_WIDTH-1] : r_a[0];

    // One shift-add step: r_acc is the running high word, r_b shifts the
    // multiplier out LSB-first while product low bits shift in from the top.
    assign w_mul_sum = r_b[0] ? ({1'b0, r_acc} + {1'b0, r_a}) : {1'b0, r_acc};
    assign w_mul_hi  = w_mul_sum[DATA_WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_b[DATA_WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_res    = '0;
        w_res_hi = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        w_err    = 1'b0;
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_op_in == c_OP_MUL) begin
                        w_next = S_MUL;
                    end else if (w_is_shift_in && (dr1[2:0] != 3'd0)) begin
                        w_next = S_SHIFT;
                    end else begin
                        w_next = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                w_load = 1'b1;
                w_next = S_DONE;
                case (r_op)
                    c_OP_ADD: begin
                        w_res = w_sum[DATA_WIDTH-1:0];
                        w_c   = w_sum[DATA_WIDTH];
                        w_v   = (r_a[DATA_WIDTH-1] == r_b[DATA_WIDTH-1]) &&
                                (w_sum[DATA_WIDTH-1] != r_a[DATA_WIDTH-1]);
                    end
                    c_OP_SUB: begin
                        w_res = w_diff[DATA_WIDTH-1:0];
                        w_c   = w_diff[DATA_WIDTH];
                        w_v   = (r_a[DATA_WIDTH-1] != r_b[DATA_WIDTH-1]) &&
                                (w_diff[DATA_WIDTH-1] != r_a[DATA_WIDTH-1]);
                    end
                    c_OP_AND: w_res = r_a & r_b;
                    c_OP_OR:  w_res = r_a | r_b;
                    c_OP_XOR: w_res = r_a ^ r_b;
                    c_OP_SHL, c_OP_SHR: w_res = r_a;
                    default:  w_err = 1'b1;
                endcase
            end
            S_SHIFT: begin
                if (r_cnt == c_CNT_W'(1)) begin
                    w_load = 1'b1;
                    w_res  = w_sh_val;
                    w_c    = w_sh_out;
                    w_next = S_DONE;
                end
            end
            S_MUL: begin
                if (r_cnt == c_CNT_W'(1)) begin
                    w_load   = 1'b1;
                    w_res    = w_mul_lo;
                    w_res_hi = w_mul_hi;
                    w_c      = |w_mul_hi;
                    w_next   = S_DONE;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_op  <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= dr0;
                        r_b   <= dr1;
                        r_op  <= w_op_in;
                        r_acc <= '0;
                        r_cnt <= (w_op_in == c_OP_MUL) ? c_CNT_W'(DATA_WIDTH)
                                                       : c_CNT_W'(dr1[2:0]);
                    end
                end
                S_SHIFT: begin
                    r_a   <= w_sh_val;
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
                S_MUL: begin
                    r_acc <= w_mul_hi;
                    r_b   <= w_mul_lo;
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Result registers only move when an op completes, so they hold while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_result_hi <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
        end else if (w_load) begin
            r_result    <= w_res;
            r_result_hi <= w_res_hi;
            r_flags     <= {(w_res == '0), w_c, w_res[DATA_WIDTH-1], w_v};
            r_err       <= w_err;
        end
    end

    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign flags     = r_flags;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
//==============================================================================
// Module   : tb_alu_sequencer
// Brief    : Scoreboard bench for alu_sequencer with directed vectors.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_alu_sequencer;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dr0;
    logic [W-1:0] dr1;
    logic [W-1:0] cr;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic [3:0]   flags;
    logic         err;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [3:0]   fl;
        logic         er;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    alu_sequencer #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dr0       (dr0),
        .dr1       (dr1),
        .cr        (cr),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation for every done pulse and checks the cycle after.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_done) begin
                check("done_one_cycle", {31'd0, done}, 32'd0);
                check("busy_fall", {31'd0, busy}, 32'd0);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", {24'd0, result}, {24'd0, e.res});
                    check("result_hi", {24'd0, result_hi}, {24'd0, e.hi});
                    check("flags", {28'd0, flags}, {28'd0, e.fl});
                    check("err", {31'd0, err}, {31'd0, e.er});
                    check("done_cycle", cyc, e.cyc);
                end
            end
            prev_done = done;
        end
    end

    task automatic push_exp(input logic [W-1:0] r, input logic [W-1:0] h,
                            input logic [3:0] f, input logic e, input int lat);
        exp_t x;
        x.res = r; x.hi = h; x.fl = f; x.er = e;
        x.cyc = cyc + 1 + lat;
        sb.push_back(x);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("timeout_idle", 32'd0, 32'd1);
    endtask

    // Issue one op at a negedge, scramble inputs afterwards, wait for completion.
    task automatic do_op(input logic [W-1:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input logic [W-1:0] h,
                         input logic [3:0] f, input logic e, input int lat);
        @(negedge clk);
        start = 1'b1; cr = c; dr0 = a; dr1 = b;
        push_exp(r, h, f, e, lat);
        @(negedge clk);
        start = 1'b0; cr = 8'h00; dr0 = ~a; dr1 = ~b;
        check("busy_rise", {31'd0, busy}, 32'd1);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0; start = 1'b0; dr0 = '0; dr1 = '0; cr = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_outs", {7'd0, result, result_hi, flags, err}, 32'd0);
        rst_n = 1'b1;

        //     cr     A      B      result hi     ZCNV     err L
        do_op(8'h00, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b0011, 0, 1);
        do_op(8'h01, 8'h05, 8'h06, 8'hFF, 8'h00, 4'b0110, 0, 1);
        do_op(8'h01, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0001, 0, 1);
        do_op(8'h05, 8'h81, 8'hF9, 8'h02, 8'h00, 4'b0100, 0, 1);
        do_op(8'h06, 8'h81, 8'h03, 8'h10, 8'h00, 4'b0000, 0, 3);
        do_op(8'h05, 8'h81, 8'h08, 8'h81, 8'h00, 4'b0010, 0, 1);
        do_op(8'h05, 8'hFF, 8'h07, 8'h80, 8'h00, 4'b0110, 0, 7);
        do_op(8'h06, 8'h80, 8'h07, 8'h01, 8'h00, 4'b0000, 0, 7);
        do_op(8'h07, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0100, 0, 8);
        do_op(8'h07, 8'h0F, 8'h11, 8'hFF, 8'h00, 4'b0010, 0, 8);
        do_op(8'h02, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 0, 1);
        do_op(8'h03, 8'h0F, 8'hF0, 8'hFF, 8'h00, 4'b0010, 0, 1);
        do_op(8'h04, 8'hAA, 8'hAA, 8'h00, 8'h00, 4'b1000, 0, 1);
        do_op(8'h00, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1100, 0, 1);

        // start held high throughout a MUL: only the MUL completes
        @(negedge clk);
        start = 1'b1; cr = 8'h07; dr0 = 8'h03; dr1 = 8'h05;
        push_exp(8'h0F, 8'h00, 4'b0000, 1'b0, 8);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cr = 8'h00; dr0 = 8'h11; dr1 = 8'h22;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!seen) check("timeout_mul_spam", 32'd0, 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("no_extra_op", {31'd0, busy}, 32'd0);
        end

        do_op(8'hFA, 8'h12, 8'h34, 8'h00, 8'h00, 4'b1000, 1, 1);
        do_op(8'h50, 8'h10, 8'h20, 8'h30, 8'h00, 4'b0000, 0, 1);

        // reset in the middle of a MUL abandons it with no done
        @(negedge clk);
        start = 1'b1; cr = 8'h07; dr0 = 8'hFF; dr1 = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_mul_busy", {31'd0, busy}, 32'd1);
        check("mid_mul_hold", {24'd0, result}, 32'h30);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_outs", {7'd0, result, result_hi, flags, err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("arst_idle", {31'd0, busy}, 32'd0);
        end

        do_op(8'h00, 8'h01, 8'h01, 8'h02, 8'h00, 4'b0000, 0, 1);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle arithmetic/logic unit sitting directly downstream of the common register file. It consumes the register file's `dr0`, `dr1` and `cr` outputs and executes the operation selected by `cr` on a `start` request. It returns a registered result, a high result word, flags and a one-cycle `done` pulse, which the controller uses to write the result back over the data bus. Single-cycle ops, iterative shifts and a shift-add multiplier share one state machine.

## Interface
- `DATA_WIDTH`, default 8: operand/result width; must be ≥ 4.
- `clk`  input  1  clock; all state changes on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  operation request; sampled only in IDLE.
- `dr0`  input  DATA_WIDTH  operand A.
- `dr1`  input  DATA_WIDTH  operand B; `dr1[2:0]` is the shift amount for shift ops.
- `cr`  input  DATA_WIDTH  control; `cr[3:0]` is the opcode, other bits are ignored.
- `busy`  output  1  high whenever state ≠ IDLE.
- `done`  output  1  one-cycle pulse; result, result_hi, flags and err are valid and stable.
- `result`  output  DATA_WIDTH  low result word.
- `result_hi`  output  DATA_WIDTH  high product word; 0 for non-MUL ops.
- `flags`  output  4  {Z, C, N, V}.
- `err`  output  1  set when the last op was illegal.

## Operation
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SHL: A by `dr1[2:0]`.
  - 6 SHR (logical): A by `dr1[2:0]`.
  - 7 MUL: unsigned A×B, 2·DATA_WIDTH-bit product.
  - 8–15: illegal.
- States: IDLE, EXEC, SHIFT, MUL, DONE.
- IDLE + `start`:
  - Latch A, B, opcode and shift count into internal registers. Later input changes have no effect on the op in flight.
  - Go to EXEC for ops 0–4, illegal ops, and shifts with count 0.
  - Go to SHIFT for shifts with count > 0.
  - Go to MUL for op 7; the iteration counter loads DATA_WIDTH.
- EXEC: compute combinationally, register the outputs, go to DONE.
- SHIFT: shift one bit per cycle and decrement the count. At count reaching 0, register the outputs and go to DONE.
- MUL: one shift-add step per cycle (multiplier LSB-first, accumulator DATA_WIDTH+1 bits). After DATA_WIDTH steps, register {result_hi, result} and go to DONE.
- DONE: `done`=1 for exactly this cycle, then return unconditionally to IDLE. `start` in DONE is ignored.
- `start` in EXEC/SHIFT/MUL/DONE is ignored; it is not queued.
- Flags, computed on the final result:
  - Z: `result`==0 (result_hi is not considered).
  - C: ADD carry-out; SUB borrow (A<B unsigned); SHL/SHR last bit shifted out (0 for count 0); MUL `result_hi`≠0; logic ops 0.
  - N: `result[DATA_WIDTH-1]`.
  - V: signed overflow for ADD/SUB; 0 otherwise.
- Illegal opcode: result=0, result_hi=0, flags={1,0,0,0}, err=1. `err` clears on the next legal op's completion.
- Outputs result, result_hi, flags and err hold their values from `done` until the next op completes. They do not change while busy.
- Reset asserted at any time, including mid-SHIFT or mid-MUL: immediately go to IDLE. The op is abandoned and no `done` is issued.

## Timing
- Reset values: busy=0, done=0, result=0, result_hi=0, flags=0, err=0, state IDLE.
- Let edge k be the edge that samples `start` in IDLE; `busy` rises after edge k.
- Latency to `done` (high after edge k+L, low after edge k+L+1):
  - Single-cycle/illegal ops and shift count 0: L=1.
  - Shifts: L=count (1–7).
  - MUL: L=DATA_WIDTH.
- `busy` falls after edge k+L+1. The next `start` is accepted at edge k+L+2 at the earliest.
- Minimum spacing between accepted starts: L+2 cycles.
- Deassertion of `rst_n` takes effect at the first rising edge after release. No `start` is sampled while `rst_n`=0.

## Test plan
- ADD A=0x7F, B=0x01: result=0x80, flags Z0 C0 N1 V1. `done` after edge k+1 for one cycle; busy is 0 two edges after k+1.
- SUB A=0x05, B=0x06: result=0xFF, flags C=1, N=1, V=0. Next, SUB 0x80−0x01: result=0x7F, V=1.
- SHL A=0x81, count 1: result=0x02, C=1, L=1. SHR A=0x81, count 3: result=0x10, C=0, L=3. SHL with count 0: result=0x81, C=0, L=1.
- MUL 0xFF×0xFF: result=0x01, result_hi=0xFE, C=1, `done` after edge k+8. MUL 0x0F×0x11: result=0xFF, result_hi=0, C=0.
- `start` pulsed every cycle during MUL: exactly one `done`, with no extra op started. Opcode 0xA: result=0, Z=1, err=1. A following ADD clears err.
- `rst_n` pulsed low at cycle 4 of a MUL: all outputs return to 0 immediately and no `done` is issued. After release, ADD 0x01+0x01 gives 0x02.
